alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle_if.sv | 25 ++
 rtl/alu_multicycle.sv | 157 +++++++++++++++
 tb/tb_alu_multicycle.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Operand/result bundle for alu_multicycle: requester drives A/B/ALU_FUN/Enable.
// The ALU returns ALU_OUT with a OUT_VALID pulse, BUSY and DIV_ERR.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_BITS   = 4
);
  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic [FUN_BITS-1:0]     ALU_FUN;
  logic                    Enable;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_VALID;
  logic                    BUSY;
  logic                    DIV_ERR;

  modport master (
    output A, B, ALU_FUN, Enable,
    input  ALU_OUT, OUT_VALID, BUSY, DIV_ERR
  );

  modport slave (
    input  A, B, ALU_FUN, Enable,
    output ALU_OUT, OUT_VALID, BUSY, DIV_ERR
  );
endinterface

// File: rtl/alu_multicycle.sv
// 16-op registered ALU: result 1 cycle after accept; with ALU_ITER_DIV_EN defined, divide takes W+1 cycles.
// BUSY (iterative divide only) makes Enable be ignored; without ALU_ITER_DIV_EN the divider is combinational.
module alu_multicycle #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_BITS   = 4
) (
  input logic             CLK,
  input logic             RST,
  alu_multicycle_if.slave bus
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0]   op_a_q, op_b_q;
  logic [3:0]     fun_q;
  logic           pend_q;
  logic [2*W-1:0] alu_out_q;
  logic           out_valid_q, div_err_q;
  logic [2*W-1:0] res_c;
  logic           err_c;
  logic [W:0]     sum_c, dif_c;
  logic           busy, accept, start_div, div_done;
  logic [2*W-1:0] div_res;

  assign accept = bus.Enable && !busy;

`ifdef ALU_ITER_DIV_EN
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    shl_c, trial_c;

  assign start_div = accept && (bus.ALU_FUN[3:0] == 4'b0011) && (bus.B != '0);
  assign busy      = (state_q == DIV);
  assign div_done  = (state_q == DONE);
  assign div_res   = {rem_q, quo_q};

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    shl_c   = {rem_q, quo_q[W-1]};
    trial_c = shl_c - {1'b0, op_b_q};
    case (state_q)
      DIV: begin
        // trial difference borrows (bit W set) exactly when shifted remainder < divisor
        if (!trial_c[W]) begin
          rem_d = trial_c[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shl_c[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (start_div) begin
      state_d = DIV;
      quo_d   = bus.A;
      rem_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign busy      = 1'b0;
  assign start_div = 1'b0;
  assign div_done  = 1'b0;
  assign div_res   = '0;
`endif

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    sum_c = {1'b0, op_a_q} + {1'b0, op_b_q};
    dif_c = {1'b0, op_a_q} - {1'b0, op_b_q};
    case (fun_q)
      4'b0000: res_c = {{(W-1){1'b0}}, sum_c};
      4'b0001: res_c = {{(W-1){1'b0}}, dif_c};
      4'b0010: res_c = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};
      4'b0011: begin
        if (op_b_q == '0) begin
          res_c = {op_a_q, {W{1'b1}}};
          err_c = 1'b1;
        end
`ifndef ALU_ITER_DIV_EN
        else res_c = {op_a_q % op_b_q, op_a_q / op_b_q};
`endif
      end
      4'b0100: res_c = {{W{1'b0}}, op_a_q & op_b_q};
      4'b0101: res_c = {{W{1'b0}}, op_a_q | op_b_q};
      4'b0110: res_c = {{W{1'b0}}, ~(op_a_q & op_b_q)};
      4'b0111: res_c = {{W{1'b0}}, ~(op_a_q | op_b_q)};
      4'b1000: res_c = {{W{1'b0}}, op_a_q ^ op_b_q};
      4'b1001: res_c = {{W{1'b0}}, ~(op_a_q ^ op_b_q)};
      4'b1010: res_c = {{(2*W-1){1'b0}}, op_a_q == op_b_q};
      4'b1011: res_c = {{(2*W-2){1'b0}}, op_a_q > op_b_q, 1'b0};
      4'b1100: res_c = {{(2*W-1){1'b0}}, op_a_q < op_b_q};
      4'b1101: res_c = {{(W+1){1'b0}}, op_a_q[W-1:1]};
      4'b1110: res_c = {{(W-1){1'b0}}, op_a_q, 1'b0};
      default: res_c = '0;
    endcase
  end

  // Divide completion and single-cycle results never coincide: nothing is accepted while in DIV.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      fun_q       <= '0;
      pend_q      <= 1'b0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      div_err_q   <= 1'b0;
      pend_q      <= accept && !start_div;
      if (accept) begin
        op_a_q <= bus.A;
        op_b_q <= bus.B;
        fun_q  <= bus.ALU_FUN[3:0];
      end
      if (div_done) begin
        alu_out_q   <= div_res;
        out_valid_q <= 1'b1;
      end else if (pend_q) begin
        alu_out_q   <= res_c;
        out_valid_q <= 1'b1;
        div_err_q   <= err_c;
      end
    end
  end

  assign bus.ALU_OUT   = alu_out_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = busy;
  assign bus.DIV_ERR   = div_err_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized bench for alu_multicycle against a cycle-indexed arithmetic model of expected results.
// Works with and without ALU_ITER_DIV_EN.
module tb_alu_multicycle;
  localparam int W = 8;
`ifdef ALU_ITER_DIV_EN
  localparam bit ITER = 1'b1;
  localparam int DIV_LAT = W + 1;
  localparam int DIV_BUSY = W;
`else
  localparam bit ITER = 1'b0;
  localparam int DIV_LAT = 1;
  localparam int DIV_BUSY = 0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  alu_multicycle_if #(.DATA_WIDTH(W), .FUN_BITS(4)) bus ();
  alu_multicycle #(.DATA_WIDTH(W), .FUN_BITS(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Expected results keyed by the cycle in which OUT_VALID must be seen.
  logic [2*W-1:0] exp_res [int];
  logic           exp_err [int];
  int             cyc = 0;
  int             div_start = -1000;
  logic [2*W-1:0] m_last = '0;

  function automatic logic [2*W-1:0] ref_alu(input int a, input int b, input int f, output logic err);
    int m = (1 << W) - 1;
    int r = 0;
    err = 1'b0;
    case (f)
      0:  r = a + b;
      1:  r = (a - b) & ((1 << (W + 1)) - 1);
      2:  r = a * b;
      3:  if (b == 0) begin r = (a << W) | m; err = 1'b1; end
          else r = ((a % b) << W) | (a / b);
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b) & m;
      7:  r = ~(a | b) & m;
      8:  r = a ^ b;
      9:  r = ~(a ^ b) & m;
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 1 : 0;
      13: r = a / 2;
      14: r = a * 2;
      default: r = 0;
    endcase
    return r[2*W-1:0];
  endfunction

  always @(posedge CLK or negedge RST) begin
    logic [2*W-1:0] r;
    logic e;
    int key;
    if (!RST) begin
      exp_res.delete();
      exp_err.delete();
      div_start = -1000;
    end else begin
      cyc = cyc + 1;
      if (bus.Enable && !((cyc - 1) >= div_start && (cyc - 1) < div_start + W)) begin
        r = ref_alu(int'(bus.A), int'(bus.B), int'(bus.ALU_FUN), e);
        if (ITER && bus.ALU_FUN == 4'd3 && bus.B != '0) begin
          div_start = cyc;
          key = cyc + W + 1;
        end else begin
          key = cyc + 1;
        end
        exp_res[key] = r;
        exp_err[key] = e;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dut=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_loop();
    bit v;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        m_last = '0;
        check("rst_alu_out", 64'(bus.ALU_OUT), 64'd0);
        check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        check("rst_div_err", 64'(bus.DIV_ERR), 64'd0);
      end else begin
        v = exp_res.exists(cyc);
        check("out_valid", 64'(bus.OUT_VALID), 64'(v));
        check("busy", 64'(bus.BUSY), 64'(cyc >= div_start && cyc < div_start + W));
        if (v) begin
          check("alu_out", 64'(bus.ALU_OUT), 64'(exp_res[cyc]));
          check("div_err", 64'(bus.DIV_ERR), 64'(exp_err[cyc]));
          m_last = exp_res[cyc];
        end else begin
          check("alu_out_hold", 64'(bus.ALU_OUT), 64'(m_last));
          check("div_err_idle", 64'(bus.DIV_ERR), 64'd0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Issue one op, then wait (bounded) for its OUT_VALID; optionally poke Enable while BUSY.
  task automatic run_op(input int a, input int b, input int f, input bit poke,
                        output logic [2*W-1:0] res, output logic err, output int lat, output int bcnt);
    tick();
    bus.A = W'(a); bus.B = W'(b); bus.ALU_FUN = 4'(f); bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.ALU_FUN = 4'($urandom);
    lat = 0; bcnt = 0; res = '0; err = 1'b0;
    while (lat < 40) begin
      @(negedge CLK);
      if (bus.OUT_VALID) begin
        res = bus.ALU_OUT;
        err = bus.DIV_ERR;
        break;
      end
      bcnt += int'(bus.BUSY);
      bus.Enable = poke && bus.BUSY && (lat < 4);
      bus.ALU_FUN = 4'd0;
      lat++;
    end
    bus.Enable = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] res;
    logic err;
    int lat, bcnt, nv;
    logic e;

    RST = 1'b0;
    bus.Enable = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
    fork compare_loop(); join_none

    check("model_add", 64'(ref_alu(200, 100, 0, e)), 64'h012C);
    check("model_sub", 64'(ref_alu(5, 9, 1, e)), 64'h01FC);
    check("model_mul", 64'(ref_alu(255, 255, 2, e)), 64'hFE01);
    check("model_div", 64'(ref_alu(100, 7, 3, e)), 64'h020E);
    check("model_div0", 64'(ref_alu(55, 0, 3, e)), 64'h37FF);
    check("model_div0_err", 64'(e), 64'd1);
    check("model_xnor", 64'(ref_alu(8'hAA, 8'h55, 9, e)), 64'h0000);

    repeat (3) tick();
    check("reset_alu_out", 64'(bus.ALU_OUT), 64'd0);
    check("reset_valid", 64'(bus.OUT_VALID), 64'd0);
    RST = 1'b1;

    run_op(200, 100, 0, 1'b0, res, err, lat, bcnt);
    check("add_res", 64'(res), 64'h012C);
    check("add_lat", 64'(lat), 64'd1);
    @(negedge CLK);
    check("add_pulse_one_cycle", 64'(bus.OUT_VALID), 64'd0);

    run_op(255, 255, 2, 1'b0, res, err, lat, bcnt);
    check("mul_res", 64'(res), 64'hFE01);
    check("mul_busy", 64'(bcnt), 64'd0);

    run_op(100, 7, 3, 1'b1, res, err, lat, bcnt);
    check("div_res", 64'(res), 64'h020E);
    check("div_lat", 64'(lat), 64'(DIV_LAT));
    check("div_busy_cycles", 64'(bcnt), 64'(DIV_BUSY));
    check("div_err_clear", 64'(err), 64'd0);

    run_op(55, 0, 3, 1'b0, res, err, lat, bcnt);
    check("div0_res", 64'(res), 64'h37FF);
    check("div0_err", 64'(err), 64'd1);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_busy", 64'(bcnt), 64'd0);

    run_op(9, 3, 11, 1'b0, res, err, lat, bcnt);
    check("gt_res", 64'(res), 64'h0002);
    run_op(9, 3, 12, 1'b0, res, err, lat, bcnt);
    check("lt_res", 64'(res), 64'h0000);
    run_op(9, 3, 6, 1'b0, res, err, lat, bcnt);
    check("nand_res", 64'(res), 64'h00FE);
    run_op(8'h80, 3, 14, 1'b0, res, err, lat, bcnt);
    check("shl_res", 64'(res), 64'h0100);

    // Abort a divide with reset in its 4th busy cycle.
    tick();
    bus.A = 8'd100; bus.B = 8'd7; bus.ALU_FUN = 4'd3; bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 64'(bus.BUSY), 64'(ITER));
    RST = 1'b0;
    #1;
    check("abort_alu_out", 64'(bus.ALU_OUT), 64'd0);
    check("abort_valid", 64'(bus.OUT_VALID), 64'd0);
    check("abort_busy", 64'(bus.BUSY), 64'd0);
    check("abort_div_err", 64'(bus.DIV_ERR), 64'd0);
    repeat (2) tick();
    RST = 1'b1;
    nv = 0;
    repeat (15) begin
      @(negedge CLK);
      nv += int'(bus.OUT_VALID);
    end
    check("abort_no_valid", 64'(nv), 64'd0);

    for (int i = 0; i < 800; i++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b0;
        bus.Enable = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
      end
      bus.Enable  = ($urandom_range(0, 99) < 55);
      bus.A       = W'($urandom);
      bus.B       = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      bus.ALU_FUN = ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom);
    end

    // Enable held high: each divide is followed immediately by an accept in its DONE cycle.
    for (int i = 0; i < 80; i++) begin
      tick();
      bus.Enable  = 1'b1;
      bus.A       = W'($urandom);
      bus.B       = W'($urandom_range(1, 255));
      bus.ALU_FUN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd3;
    end

    tick();
    bus.Enable = 1'b0;
    repeat (W + 6) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
